mem_requester: RTL
==================

Name: mem_requester

Overview:
- Initiator-side load/store engine that drives one port of the team's single-port word RAM.
- Accepts byte, half and word load/store requests from the pipeline over a valid/ready handshake.
- Translates each request into RAM word accesses: a read-modify-write sequence for sub-word stores, and sign/zero extension for loads.
- Returns one response per request over a second valid/ready handshake. It sits between the execute stage and the data RAM.

Parameters:
- XLEN, 32, data and address width of the request and response interfaces.
- DEPTH, 1024, number of XLEN-bit words in the attached RAM.
- AW, $clog2(DEPTH), RAM word-address width (derived, do not override).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend load result (byte/half only).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  XLEN  load result, extended; 0 for stores and errors.
- resp_error  out  1  misaligned, illegal size, or out-of-range address.
- ram_write_ena  out  1  RAM write enable; the RAM writes on the negedge of the same cycle.
- ram_addr  out  AW  RAM word address.
- ram_data_o  out  XLEN  write data to RAM.
- ram_data_i  in  XLEN  combinational read data from RAM.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (async, any state): state = IDLE, and all of the following are 0 immediately:
  - resp_valid, resp_error, resp_rdata
  - ram_write_ena, ram_addr, ram_data_o
  - latched request
- An in-flight operation is dropped on reset. No partial write completes after reset asserts.
- IDLE:
  - req_ready = 1.
  - Accept on posedge with req_valid = 1. Latch write, size, unsigned, addr, wdata.
- Error check at accept. The request is an error if any of:
  - size = 3
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[XLEN-1:AW+2] != 0
- Error request: go to RESP with resp_error = 1 and resp_rdata = 0. No RAM activity (ram_write_ena stays 0).
- Load: go to READ.
- Word store: go to WRITE.
- Sub-word store: go to READ.
- READ:
  - ram_addr = latched addr[AW+1:2]; ram_write_ena = 0.
  - At posedge, capture ram_data_i.
  - Load: extract the lane at addr[1:0] (byte) or addr[1] (half), sign- or zero-extend per unsigned, write to resp_rdata, go to RESP.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of the captured word and hold it as the merge word. Go to WRITE.
- WRITE:
  - ram_write_ena = 1 for exactly this one cycle (combinational from state).
  - ram_addr = latched word address.
  - ram_data_o = wdata (word store) or the merge word (sub-word store). ram_data_o is stable for the whole cycle.
  - Next state RESP with resp_rdata = 0 and resp_error = 0.
- RESP:
  - resp_valid = 1; outputs are held until resp_ready = 1 at a posedge, then go to IDLE.
  - req_ready = 0 in READ, WRITE and RESP; there is no pipelining, and at most one request is outstanding.
- Latency from accept edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Response ordering: every accepted request yields exactly one response, in order.
- ram_addr and ram_data_o hold their last value in IDLE and RESP. ram_write_ena = 0 outside WRITE.
- Back-to-back: a new request can be accepted on the edge after the response handshake.

Test Plan:
- Reset mid-WRITE, then release → ram_write_ena falls immediately, resp_valid = 0, state IDLE, RAM word unchanged if reset precedes the negedge.
- SW addr 0x10, data 0xDEADBEEF; then LW 0x10 → ram_addr = 4, one write pulse; load returns 0xDEADBEEF with resp_error = 0.
- SB addr 0x13, data 0x80 over RAM word 0x11223344; then LB 0x13 and LBU 0x13 → word becomes 0x80223344; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH addr 0x12, data 0xABCD over 0xDEADBEEF → word becomes 0xABCDBEEF; LH 0x12 returns 0xFFFFABCD.
- LW addr 0x11, SH addr 0x03, req_size = 3, and addr 4*DEPTH → each gives resp_error = 1, resp_rdata = 0, ram_write_ena never asserted, 1-cycle latency.
- Load with resp_ready held low 5 cycles → resp_valid and resp_rdata stable, req_ready = 0, no second accept; proceeds to IDLE on handshake.

Source files
------------

// File: rtl/mem_requester.sv
// Load/store engine driving one port of a single-port word RAM.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module mem_requester #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic            ram_write_ena,
    output logic [AW-1:0]   ram_addr,
    output logic [XLEN-1:0] ram_data_o,
    input  logic [XLEN-1:0] ram_data_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [1:0]      offset_q, offset_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [XLEN-1:0] ram_data_q, ram_data_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_error_q, resp_error_d;

    logic            req_err;
    logic [7:0]      rd_bytes [4];
    logic [15:0]     rd_halves [2];
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] merge_word;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign rd_bytes[gi] = ram_data_i[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_halves
        assign rd_halves[gi] = ram_data_i[16*gi +: 16];
    end

    assign req_err = (req_size == 2'd3)
                  || (req_size == 2'd1 && req_addr[0])
                  || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                  || (req_addr[XLEN-1:AW+2] != '0);

    // Lane extraction for loads and lane merge for sub-word stores share the same read word.
    always_comb begin
        lane_b = rd_bytes[offset_q];
        lane_h = rd_halves[offset_q[1]];
        case (size_q)
            2'd0:    load_ext = {{(XLEN-8){~unsigned_q & lane_b[7]}}, lane_b};
            2'd1:    load_ext = {{(XLEN-16){~unsigned_q & lane_h[15]}}, lane_h};
            default: load_ext = ram_data_i;
        endcase
        merge_word = ram_data_i;
        if (size_q == 2'd0)
            merge_word[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_word[{offset_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d      = req_write;
                    size_d       = req_size;
                    unsigned_d   = req_unsigned;
                    offset_d     = req_addr[1:0];
                    wdata_d      = req_wdata[15:0];
                    resp_rdata_d = '0;
                    resp_error_d = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        ram_addr_d = req_addr[AW+1:2];
                        if (req_write && req_size == 2'd2) begin
                            ram_data_d = req_wdata;
                            state_d    = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    ram_data_d = merge_word;
                    state_d    = WRITE;
                end else begin
                    resp_rdata_d = load_ext;
                    state_d      = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            offset_q     <= '0;
            wdata_q      <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Write enable decodes straight from state so an async reset kills a pending write at once.
    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign ram_write_ena = (state_q == WRITE);
    assign ram_addr      = ram_addr_q;
    assign ram_data_o    = ram_data_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_error    = resp_error_q;
endmodule
